alu_ctrl_mc: RTL

//  Next-generation ALU controller for the single-cycle MIPS core. Decodes ALUOp_i/funct_i into
//  the 4-bit ALU control, and adds multi-cycle MULT/MULTU/DIV/DIVU through an iterative

---
 rtl/alu_ctrl_mc_pkg.sv | 58 +++++
 rtl/alu_ctrl_mc_if.sv | 33 +++
 rtl/alu_ctrl_mc_mdu_iter.sv | 114 +++++++++++
 rtl/alu_ctrl_mc.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_mc_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared codes for the multi-cycle ALU controller: ALUOp and funct encodings
// coming from the main decoder, the 4-bit ALU control codes, the MFHI/MFLO
// write-back select codes and the mul/div sequencing FSM state.
// Optional feature macro used by the files importing this package:
//   ALU_CTRL_MC_DIV_EN - enables DIV/DIVU (divider datapath and decode).
// -----------------------------------------------------------------------------
package alu_ctrl_pkg;

    // ALUOp field from the main decoder
    localparam logic [2:0] ALUOP_BRANCH = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE  = 3'b010;
    localparam logic [2:0] ALUOP_ADDI   = 3'b100;
    localparam logic [2:0] ALUOP_SLTI   = 3'b101;
    localparam logic [2:0] ALUOP_LUI    = 3'b110;
    localparam logic [2:0] ALUOP_ORI    = 3'b111;

    // R-type function field
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    // ALU control codes
    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_NOR  = 4'b1100,
        ALU_NONE = 4'b1111
    } alu_ctrl_t;

    // Write-back source select for MFHI/MFLO
    typedef enum logic [1:0] {
        MF_ALU = 2'b00,
        MF_HI  = 2'b01,
        MF_LO  = 2'b10
    } mf_sel_t;

    // Mul/div sequencing
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_ctrl_mc_if.sv
// -----------------------------------------------------------------------------
// alu_ctrl_mc_if
// Decode-stage bundle between the main decoder/pipeline and alu_ctrl_mc.
//   valid_i, ALUOp_i, funct_i, src1_i, src2_i : decoder -> controller
//   ALUCtrl_o, stall_o, hi_o, lo_o, mf_sel_o, illegal_o : controller -> pipeline
// modport master : pipeline side (drives instruction fields)
// modport slave  : controller side
// -----------------------------------------------------------------------------
interface alu_ctrl_mc_if #(
    parameter int DATA_W = 32
);
    logic              valid_i;
    logic [2:0]        ALUOp_i;
    logic [5:0]        funct_i;
    logic [DATA_W-1:0] src1_i;
    logic [DATA_W-1:0] src2_i;
    logic [3:0]        ALUCtrl_o;
    logic              stall_o;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;
    logic [1:0]        mf_sel_o;
    logic              illegal_o;

    modport master (
        output valid_i, ALUOp_i, funct_i, src1_i, src2_i,
        input  ALUCtrl_o, stall_o, hi_o, lo_o, mf_sel_o, illegal_o
    );

    modport slave (
        input  valid_i, ALUOp_i, funct_i, src1_i, src2_i,
        output ALUCtrl_o, stall_o, hi_o, lo_o, mf_sel_o, illegal_o
    );
endinterface

// File: rtl/alu_ctrl_mc_mdu_iter.sv
// -----------------------------------------------------------------------------
// mdu_iter
// Unsigned iterative multiply/divide core, one bit per step.
//   Multiply : shift-add, {res_hi,res_lo} = op_a * op_b after DATA_W steps.
//   Divide   : restoring, res_lo = op_a / op_b, res_hi = op_a % op_b
//              (only when ALU_CTRL_MC_DIV_EN is defined).
// Ports
//   clk, srst        clock, synchronous active-high reset
//   start            load operands (one cycle)
//   step             perform one iteration this cycle
//   is_div           select divide (present only with ALU_CTRL_MC_DIV_EN)
//   op_a, op_b       unsigned multiplicand/multiplier or dividend/divisor
//   res_hi, res_lo   value the partial registers take after the current step;
//                    on the final step this is the finished result, so the
//                    caller can commit it on the same edge.
// Sign handling and the iteration count live in the caller.
// -----------------------------------------------------------------------------
module mdu_iter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              start,
    input  logic              step,
`ifdef ALU_CTRL_MC_DIV_EN
    input  logic              is_div,
`endif
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] res_hi,
    output logic [DATA_W-1:0] res_lo
);
    // hi_reg: partial product high half / partial remainder
    // lo_reg: multiplier being shifted out / dividend shifting into quotient
    // opnd_reg: multiplicand / divisor
    logic [DATA_W-1:0] hi_reg, lo_reg, opnd_reg;
    logic [DATA_W-1:0] hi_next, lo_next;
    logic [DATA_W-1:0] load_lo, load_opnd;
    logic [DATA_W:0]   mul_sum;

    always_ff @(posedge clk) begin
        if (srst) begin
            hi_reg   <= '0;
            lo_reg   <= '0;
            opnd_reg <= '0;
        end else if (start) begin
            hi_reg   <= '0;
            lo_reg   <= load_lo;
            opnd_reg <= load_opnd;
        end else if (step) begin
            hi_reg   <= hi_next;
            lo_reg   <= lo_next;
        end
    end

    // Add multiplicand when the current multiplier LSB is set, then shift
    // the whole {carry,hi,lo} right by one.
    always_comb begin
        mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
    end

`ifdef ALU_CTRL_MC_DIV_EN
    logic              div_reg;
    logic [DATA_W:0]   div_shift;
    logic [DATA_W:0]   div_diff;

    always_ff @(posedge clk) begin
        if (srst) begin
            div_reg <= 1'b0;
        end else if (start) begin
            div_reg <= is_div;
        end
    end

    always_comb begin
        load_lo   = is_div ? op_a : op_b;
        load_opnd = is_div ? op_b : op_a;
    end

    // Restoring step: shift next dividend bit into the remainder and
    // subtract the divisor if it fits. The shifted remainder is always
    // below 2*divisor, so a non-negative difference fits in DATA_W bits.
    always_comb begin
        div_shift = {hi_reg, lo_reg[DATA_W-1]};
        div_diff  = div_shift - {1'b0, opnd_reg};
        if (div_reg) begin
            if (div_diff[DATA_W]) begin
                hi_next = div_shift[DATA_W-1:0];
                lo_next = {lo_reg[DATA_W-2:0], 1'b0};
            end else begin
                hi_next = div_diff[DATA_W-1:0];
                lo_next = {lo_reg[DATA_W-2:0], 1'b1};
            end
        end else begin
            hi_next = mul_sum[DATA_W:1];
            lo_next = {mul_sum[0], lo_reg[DATA_W-1:1]};
        end
    end
`else
    always_comb begin
        load_lo   = op_b;
        load_opnd = op_a;
    end

    always_comb begin
        hi_next = mul_sum[DATA_W:1];
        lo_next = {mul_sum[0], lo_reg[DATA_W-1:1]};
    end
`endif

    assign res_hi = hi_next;
    assign res_lo = lo_next;

endmodule

// File: rtl/alu_ctrl_mc.sv
// -----------------------------------------------------------------------------
// alu_ctrl_mc
// ALU controller for the MIPS core with multi-cycle MULT/MULTU (and DIV/DIVU
// when ALU_CTRL_MC_DIV_EN is defined). Decodes ALUOp/funct combinationally,
// sequences the iterative multiply/divide unit, owns HI/LO and stalls PC/IF
// until a mul/div retires.
// Ports
//   clk_i   clock, rising edge
//   rst_i   synchronous reset, active-high (aborts any op in flight)
//   bus     alu_ctrl_mc_if.slave: valid_i, ALUOp_i, funct_i, src1_i, src2_i in;
//           ALUCtrl_o, stall_o, hi_o, lo_o, mf_sel_o, illegal_o out
// Parameters
//   DATA_W  operand / HI / LO width, also the iteration count
//   CNT_W   iteration counter width, 2**CNT_W > DATA_W
// Configuration macro: ALU_CTRL_MC_DIV_EN (divider present; otherwise DIV/DIVU
// decode as illegal and never issue).
// Timing: issue cycle (stall) -> DATA_W BUSY cycles (stall) -> DONE (no stall,
// result visible) -> IDLE. Divide by zero goes straight to DONE.
// -----------------------------------------------------------------------------
module alu_ctrl_mc
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic           clk_i,
    input  logic           rst_i,
    alu_ctrl_mc_if.slave   bus
);
    // ---------------- decode ----------------
    alu_ctrl_t alu_ctrl;
    mf_sel_t   mf_sel;
    logic      undecodable;
    logic      md_op, md_signed, md_div;

    always_comb begin
        alu_ctrl    = ALU_NONE;
        mf_sel      = MF_ALU;
        undecodable = 1'b0;
        md_op       = 1'b0;
        md_signed   = 1'b0;
        md_div      = 1'b0;
        case (bus.ALUOp_i)
            ALUOP_BRANCH: alu_ctrl = ALU_SUB;
            ALUOP_ADDI:   alu_ctrl = ALU_ADD;
            ALUOP_SLTI:   alu_ctrl = ALU_SLT;
            ALUOP_LUI:    alu_ctrl = ALU_ADD;
            ALUOP_ORI:    alu_ctrl = ALU_OR;
            ALUOP_RTYPE: begin
                case (bus.funct_i)
                    FUNCT_ADD:   alu_ctrl = ALU_ADD;
                    FUNCT_SUB:   alu_ctrl = ALU_SUB;
                    FUNCT_AND:   alu_ctrl = ALU_AND;
                    FUNCT_OR:    alu_ctrl = ALU_OR;
                    FUNCT_NOR:   alu_ctrl = ALU_NOR;
                    FUNCT_SLT:   alu_ctrl = ALU_SLT;
                    FUNCT_MFHI:  mf_sel   = MF_HI;
                    FUNCT_MFLO:  mf_sel   = MF_LO;
                    FUNCT_MULT: begin
                        md_op     = 1'b1;
                        md_signed = 1'b1;
                    end
                    FUNCT_MULTU: md_op = 1'b1;
`ifdef ALU_CTRL_MC_DIV_EN
                    FUNCT_DIV: begin
                        md_op     = 1'b1;
                        md_signed = 1'b1;
                        md_div    = 1'b1;
                    end
                    FUNCT_DIVU: begin
                        md_op     = 1'b1;
                        md_div    = 1'b1;
                    end
`endif
                    default: undecodable = 1'b1;
                endcase
            end
            default: undecodable = 1'b1;  // 000 / 011 carry no meaning
        endcase
    end

    assign bus.ALUCtrl_o = alu_ctrl;
    assign bus.mf_sel_o  = mf_sel;
    assign bus.illegal_o = bus.valid_i & undecodable;

    // ---------------- FSM ----------------
    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic              issue, div_zero, last_iter, stall;

    assign issue     = (state_reg == ST_IDLE) && bus.valid_i && md_op;
    assign div_zero  = md_div && (bus.src2_i == '0);
    assign last_iter = (state_reg == ST_BUSY) && (cnt_reg == CNT_W'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (issue) state_next = div_zero ? ST_DONE : ST_BUSY;
            ST_BUSY: if (cnt_reg == CNT_W'(1)) state_next = ST_DONE;
            // DONE never re-issues: the held instruction retires here.
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        stall = 1'b0;
        case (state_reg)
            ST_IDLE: stall = issue;
            ST_BUSY: stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    assign bus.stall_o = stall;

    // ---------------- datapath ----------------
    logic [DATA_W-1:0]   mag_a, mag_b;
    logic [DATA_W-1:0]   md_hi, md_lo;
    logic [DATA_W-1:0]   hi_reg, lo_reg;
    logic [DATA_W-1:0]   fix_hi, fix_lo;
    logic [2*DATA_W-1:0] prod;
    logic                neg_q_reg, neg_r_reg, div_reg;

    // The core works on magnitudes; signs are re-applied on the last edge.
    always_comb begin
        mag_a = (md_signed && bus.src1_i[DATA_W-1]) ? -bus.src1_i : bus.src1_i;
        mag_b = (md_signed && bus.src2_i[DATA_W-1]) ? -bus.src2_i : bus.src2_i;
    end

    mdu_iter #(
        .DATA_W (DATA_W)
    ) u_mdu (
        .clk    (clk_i),
        .srst   (rst_i),
        .start  (issue && !div_zero),
        .step   (state_reg == ST_BUSY),
`ifdef ALU_CTRL_MC_DIV_EN
        .is_div (md_div),
`endif
        .op_a   (mag_a),
        .op_b   (mag_b),
        .res_hi (md_hi),
        .res_lo (md_lo)
    );

    // Quotient/product negate when operand signs differ; the remainder
    // follows the dividend's sign.
    always_comb begin
        prod = {md_hi, md_lo};
        if (neg_q_reg) prod = -prod;
        fix_hi = prod[2*DATA_W-1:DATA_W];
        fix_lo = prod[DATA_W-1:0];
        if (div_reg) begin
            fix_lo = neg_q_reg ? -md_lo : md_lo;
            fix_hi = neg_r_reg ? -md_hi : md_hi;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_reg   <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            div_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (issue) begin
                        neg_q_reg <= md_signed & (bus.src1_i[DATA_W-1] ^ bus.src2_i[DATA_W-1]);
                        neg_r_reg <= md_signed & bus.src1_i[DATA_W-1];
                        div_reg   <= md_div;
                        if (div_zero) begin
                            lo_reg <= '1;
                            hi_reg <= bus.src1_i;
                        end else begin
                            cnt_reg <= CNT_W'(DATA_W);
                        end
                    end
                end
                ST_BUSY: begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (last_iter) begin
                        hi_reg <= fix_hi;
                        lo_reg <= fix_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi_o = hi_reg;
    assign bus.lo_o = lo_reg;

endmodule
